// File: rtl/ahblite3_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : ahblite3_sram_slave
// Description : AHB-Lite slave backed by a word-organised RAM. It serves cache
//               line refills and write-throughs, and inserts WAIT_STATES
//               HREADYOUT-low cycles per data phase to stretch miss latency.
//               Illegal transfers (bad size, misalignment, and optionally
//               out-of-range addresses) get a two-cycle ERROR response.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              in   clock
//   reset            in   asynchronous, active-high reset
//   io_ahb_HADDR     in   transfer address (AW bits)
//   io_ahb_HSEL      in   slave select
//   io_ahb_HREADY    in   bus ready (previous transfer complete)
//   io_ahb_HWRITE    in   1 = write
//   io_ahb_HSIZE     in   0 = byte, 1 = half, 2 = word, others illegal
//   io_ahb_HBURST    in   ignored
//   io_ahb_HPROT     in   ignored
//   io_ahb_HTRANS    in   IDLE/BUSY/NONSEQ/SEQ
//   io_ahb_HMASTLOCK in   ignored
//   io_ahb_HWDATA    in   write data (data phase)
//   io_ahb_HRDATA    out  read data, full word; zero outside WAIT/LAST
//   io_ahb_HREADYOUT out  data-phase complete
//   io_ahb_HRESP     out  0 = OKAY, 1 = ERROR
// Build option
//   AHB_SRAM_RANGE_ERR_EN : when defined, addresses at or above
//                           DEPTH_WORDS*4 are ERROR; otherwise the word
//                           index wraps modulo DEPTH_WORDS.
// ============================================================================
module ahblite3_sram_slave #(
    parameter int AW          = 24,
    parameter int DW          = 32,   // only 32 is supported
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_STATES = 1     // 0..7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] io_ahb_HADDR,
    input  logic          io_ahb_HSEL,
    input  logic          io_ahb_HREADY,
    input  logic          io_ahb_HWRITE,
    input  logic [2:0]    io_ahb_HSIZE,
    input  logic [2:0]    io_ahb_HBURST,
    input  logic [3:0]    io_ahb_HPROT,
    input  logic [1:0]    io_ahb_HTRANS,
    input  logic          io_ahb_HMASTLOCK,
    input  logic [DW-1:0] io_ahb_HWDATA,
    output logic [DW-1:0] io_ahb_HRDATA,
    output logic          io_ahb_HREADYOUT,
    output logic          io_ahb_HRESP
);

    localparam int         c_IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int         c_LANES    = DW / 8;
    localparam bit         c_HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [2:0] c_WS_LOAD  = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [AW-3:0] c_DEPTH = (AW-2)'(DEPTH_WORDS);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_LAST = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         r_cnt;
    logic [AW-1:0]      r_addr;
    logic               r_write;
    logic [2:0]         r_size;
    logic [DW-1:0]      r_mem [DEPTH_WORDS];

    logic [2:0]         w_state_nxt;
    logic [2:0]         w_cnt_nxt;
    logic               w_take;
    logic               w_accept;
    logic               w_illegal;
    logic               w_readyout;
    logic               w_resp;
    logic               w_rd_en;
    logic [c_IDX_W-1:0] w_idx;
    logic [DW-1:0]      w_rd_word;
    logic [DW-1:0]      w_wr_word;
    logic [c_LANES-1:0] w_be;
    logic               w_wr_en;
    logic               w_unused;

    // Burst type, protection, lock and the BUSY/SEQ distinction have no
    // effect on a single-ported RAM.
    assign w_unused = ^{io_ahb_HBURST, io_ahb_HPROT, io_ahb_HMASTLOCK, io_ahb_HTRANS[0]};

    assign w_accept = io_ahb_HSEL & io_ahb_HREADY & io_ahb_HTRANS[1];

`ifdef AHB_SRAM_RANGE_ERR_EN
    localparam logic [AW:0] c_BYTE_LIMIT = (AW+1)'(DEPTH_WORDS) << 2;
`endif

    // Legality of the transfer currently in its address phase.
    always_comb begin
        w_illegal = 1'b0;
        case (io_ahb_HSIZE)
            3'd0:    w_illegal = 1'b0;
            3'd1:    w_illegal = io_ahb_HADDR[0];
            3'd2:    w_illegal = (io_ahb_HADDR[1:0] != 2'b00);
            default: w_illegal = 1'b1;
        endcase
`ifdef AHB_SRAM_RANGE_ERR_EN
        if ({1'b0, io_ahb_HADDR} >= c_BYTE_LIMIT) begin
            w_illegal = 1'b1;
        end
`endif
    end

    // Next-state and bus outputs. IDLE, LAST and ERR2 are the only states
    // in which HREADYOUT is high, so they are the only ones that can take a
    // new address phase.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_take      = 1'b0;
        w_readyout  = 1'b1;
        w_resp      = 1'b0;
        w_rd_en     = 1'b0;
        case (r_state)
            S_IDLE, S_LAST, S_ERR2: begin
                w_resp  = (r_state == S_ERR2);
                w_rd_en = (r_state == S_LAST);
                if (w_accept) begin
                    w_take = 1'b1;
                    if (w_illegal) begin
                        w_state_nxt = S_ERR1;
                    end else if (c_HAS_WAIT) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = c_WS_LOAD;
                    end else begin
                        w_state_nxt = S_LAST;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                w_readyout = 1'b0;
                w_rd_en    = 1'b1;
                if (r_cnt == 3'd0) begin
                    w_state_nxt = S_LAST;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            S_ERR1: begin
                w_readyout  = 1'b0;
                w_resp      = 1'b1;
                w_state_nxt = S_ERR2;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_take) begin
                r_addr  <= io_ahb_HADDR;
                r_write <= io_ahb_HWRITE;
                r_size  <= io_ahb_HSIZE;
            end
        end
    end

    // Upper address bits beyond the RAM depth alias back into it.
    assign w_idx     = c_IDX_W'(r_addr[AW-1:2] % c_DEPTH);
    assign w_rd_word = r_mem[w_idx];

    always_comb begin
        w_be = '0;
        case (r_size)
            3'd0:    w_be[r_addr[1:0]] = 1'b1;
            3'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            3'd2:    w_be = '1;
            default: w_be = '0;
        endcase
    end

    // Merge enabled byte lanes of HWDATA into the current word.
    for (genvar gi = 0; gi < c_LANES; gi++) begin : g_lane
        assign w_wr_word[8*gi +: 8] = w_be[gi] ? io_ahb_HWDATA[8*gi +: 8]
                                               : w_rd_word[8*gi +: 8];
    end

    // Only a legal transfer ever reaches LAST, so ERROR transfers never
    // write. The reset term drops a write whose final edge coincides with
    // reset assertion.
    assign w_wr_en = (r_state == S_LAST) && r_write && !reset;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_idx] <= w_wr_word;
        end
    end

    assign io_ahb_HREADYOUT = w_readyout;
    assign io_ahb_HRESP     = w_resp;
    assign io_ahb_HRDATA    = w_rd_en ? w_rd_word : '0;

endmodule
`default_nettype wire

// File: tb/tb_ahblite3_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahblite3_sram_slave
// Description : Scoreboard bench for ahblite3_sram_slave. Two instances are
//               built (WAIT_STATES = 2 and 0); one is active at a time. The
//               driver pushes the expected response of each transfer from a
//               byte-level memory model; a negedge monitor pops and compares
//               when the data phase completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahblite3_sram_slave;

    localparam int AW    = 24;
    localparam int DW    = 32;
    localparam int DEPTH = 4096;
    localparam int MEMB  = DEPTH * 4;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;

    typedef struct {
        int          kind;   // 0 = transfer, 1 = IDLE, 2 = not selected
        logic        wr;
        logic [2:0]  sz;
        logic [AW-1:0] a;
        logic [31:0] wd;
        logic [1:0]  tr;
    } item_t;

    typedef struct {
        logic        err;
        int          waits;
        logic        wr;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [AW-1:0] haddr;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [1:0]    htrans;
    logic          hsel_a;
    logic [31:0]   hwdata;
    logic [2:0]    hburst;
    logic [3:0]    hprot;
    logic          hlock;
    int            sel;

    logic        hsel0, hsel1, ro0, ro1, rsp0, rsp1;
    logic [31:0] rd0, rd1;
    logic        rdy_a, rsp_a;
    logic [31:0] rd_a;

    assign hsel0 = hsel_a && (sel == 0);
    assign hsel1 = hsel_a && (sel == 1);
    assign rdy_a = (sel == 0) ? ro0  : ro1;
    assign rsp_a = (sel == 0) ? rsp0 : rsp1;
    assign rd_a  = (sel == 0) ? rd0  : rd1;

    ahblite3_sram_slave #(.AW(AW), .DW(DW), .DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) u_dut_ws2 (
        .clk(clk), .reset(reset),
        .io_ahb_HADDR(haddr), .io_ahb_HSEL(hsel0), .io_ahb_HREADY(ro0),
        .io_ahb_HWRITE(hwrite), .io_ahb_HSIZE(hsize), .io_ahb_HBURST(hburst),
        .io_ahb_HPROT(hprot), .io_ahb_HTRANS(htrans), .io_ahb_HMASTLOCK(hlock),
        .io_ahb_HWDATA(hwdata), .io_ahb_HRDATA(rd0), .io_ahb_HREADYOUT(ro0),
        .io_ahb_HRESP(rsp0)
    );

    ahblite3_sram_slave #(.AW(AW), .DW(DW), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .reset(reset),
        .io_ahb_HADDR(haddr), .io_ahb_HSEL(hsel1), .io_ahb_HREADY(ro1),
        .io_ahb_HWRITE(hwrite), .io_ahb_HSIZE(hsize), .io_ahb_HBURST(hburst),
        .io_ahb_HPROT(hprot), .io_ahb_HTRANS(htrans), .io_ahb_HMASTLOCK(hlock),
        .io_ahb_HWDATA(hwdata), .io_ahb_HRDATA(rd1), .io_ahb_HREADYOUT(ro1),
        .io_ahb_HRESP(rsp1)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sbq[$];
    logic [7:0] mem_m [2][MEMB];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: sequential byte-addressed memory, applied in issue order.
    task automatic model_push(input logic wr, input logic [2:0] sz,
                              input logic [AW-1:0] a, input logic [31:0] wd);
        exp_t e;
        int   ba, nb;
        logic err;
        nb  = 1 << int'(sz);
        err = (sz > 3'd2) || ((int'(a) % nb) != 0);
`ifdef AHB_SRAM_RANGE_ERR_EN
        if (int'(a) >= MEMB) err = 1'b1;
`endif
        ba      = int'(a) % MEMB;
        e.err   = err;
        e.waits = err ? 1 : ((sel == 0) ? 2 : 0);
        e.wr    = wr;
        e.rdata = '0;
        if (!err) begin
            if (wr) begin
                for (int k = 0; k < nb; k++)
                    mem_m[sel][ba + k] = wd[8*((ba + k) % 4) +: 8];
            end else begin
                for (int k = 0; k < 4; k++)
                    e.rdata[8*k +: 8] = mem_m[sel][(ba & ~3) + k];
            end
        end
        sbq.push_back(e);
    endtask

    function automatic item_t mk(input int kind, input logic wr, input logic [2:0] sz,
                                 input logic [AW-1:0] a, input logic [31:0] wd,
                                 input logic [1:0] tr);
        item_t it;
        it.kind = kind; it.wr = wr; it.sz = sz; it.a = a; it.wd = wd; it.tr = tr;
        return it;
    endfunction

    // Drive one address phase (called at posedge+1) and return once it has
    // been taken; then drive HWDATA for its data phase.
    task automatic present(input item_t it);
        logic r;
        int   n;
        haddr  = it.a;
        hwrite = it.wr;
        hsize  = it.sz;
        case (it.kind)
            0: begin
                hsel_a = 1'b1;
                htrans = it.tr;
                model_push(it.wr, it.sz, it.a, it.wd);
            end
            1: begin
                hsel_a = 1'b1;
                htrans = 2'b00;
            end
            default: begin
                hsel_a = 1'b0;
                htrans = NS;
            end
        endcase
        n = 0;
        forever begin
            r = rdy_a;
            @(posedge clk);
            #1;
            if (r) break;
            n++;
            if (n > 40) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout: HREADYOUT low for %0d cycles, required at most 8", n);
                break;
            end
        end
        hwdata = (it.kind == 0 && it.wr) ? it.wd : $urandom;
    endtask

    function automatic item_t rnd_item();
        item_t it;
        int    p, q;
        logic [AW-1:0] base;
        p = $urandom_range(0, 99);
        it.kind = (p < 8) ? 1 : (p < 14) ? 2 : 0;
        it.wr   = 1'($urandom_range(0, 1));
        q = $urandom_range(0, 19);
        it.sz   = (q < 6) ? 3'd0 : (q < 12) ? 3'd1 : (q < 18) ? 3'd2 : 3'($urandom_range(3, 7));
        base = AW'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) base = base + AW'(32'h4000 * $urandom_range(1, 3));
        it.a  = base;
        it.wd = $urandom;
        it.tr = $urandom_range(0, 1) ? SQ : NS;
        return it;
    endfunction

    task automatic drain(input string name);
        present(mk(1, 1'b0, 3'd0, '0, '0, 2'b00));
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check(name, 32'(sbq.size()), 32'd0);
    endtask

    task automatic init_region();
        for (int w = 0; w < 64; w++)
            present(mk(0, 1'b1, 3'd2, AW'(w * 4), $urandom, NS));
    endtask

    // Monitor: follows data phases of the active instance.
    bit   in_dp = 1'b0;
    int   waits = 0;
    bit   resp_bad = 1'b0;
    always @(negedge clk) begin : p_mon
        exp_t e;
        logic exp_err;
        if (reset) begin
            in_dp = 1'b0;
        end else begin
            if (in_dp) begin
                exp_err = (sbq.size() > 0) ? sbq[0].err : 1'b0;
                if (!rdy_a) begin
                    waits++;
                    if (rsp_a !== exp_err) resp_bad = 1'b1;
                end else begin
                    if (sbq.size() == 0) begin
                        check("sb_empty", 32'd1, 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        check("hresp", 32'(rsp_a), 32'(e.err));
                        check("wait_cycles", 32'(waits), 32'(e.waits));
                        check("hresp_low_cycles", 32'(resp_bad), 32'd0);
                        if (e.err) check("hrdata_err", rd_a, 32'd0);
                        else if (!e.wr) check("hrdata", rd_a, e.rdata);
                    end
                    in_dp = 1'b0;
                end
            end else begin
                check("idle_hreadyout", 32'(rdy_a), 32'd1);
                check("idle_hresp", 32'(rsp_a), 32'd0);
                check("idle_hrdata", rd_a, 32'd0);
            end
            if (rdy_a && hsel_a && htrans[1]) begin
                in_dp    = 1'b1;
                waits    = 0;
                resp_bad = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        sel    = 0;
        haddr  = '0;
        hwrite = 1'b0;
        hsize  = 3'd0;
        htrans = 2'b00;
        hsel_a = 1'b0;
        hwdata = '0;
        hburst = 3'd0;
        hprot  = 4'd0;
        hlock  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hreadyout_ws2", 32'(ro0), 32'd1);
        check("rst_hresp_ws2", 32'(rsp0), 32'd0);
        check("rst_hrdata_ws2", rd0, 32'd0);
        check("rst_hreadyout_ws0", 32'(ro1), 32'd1);
        check("rst_hresp_ws0", 32'(rsp1), 32'd0);
        check("rst_hrdata_ws0", rd1, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) present(mk(1, 1'b0, 3'd0, '0, '0, 2'b00));

        // ---- WAIT_STATES = 2 instance ----
        sel = 0;
        present(mk(0, 1'b1, 3'd2, 24'h000010, 32'hDEADBEEF, NS));
        present(mk(0, 1'b0, 3'd2, 24'h000010, 32'h0, NS));
        present(mk(0, 1'b1, 3'd2, 24'h000020, 32'h00000000, NS));
        present(mk(0, 1'b1, 3'd0, 24'h000021, 32'h0000AA00, NS));
        present(mk(0, 1'b1, 3'd1, 24'h000022, 32'h55660000, NS));
        present(mk(0, 1'b0, 3'd2, 24'h000020, 32'h0, NS));
        present(mk(0, 1'b1, 3'd2, 24'h000000, 32'h12345678, NS));
        present(mk(0, 1'b0, 3'd2, 24'h000002, 32'h0, NS));
        present(mk(0, 1'b1, 3'd2, 24'h000002, 32'hFFFFFFFF, NS));
        present(mk(0, 1'b1, 3'd1, 24'h000001, 32'hFFFFFFFF, NS));
        present(mk(0, 1'b1, 3'd3, 24'h000000, 32'hFFFFFFFF, NS));
        present(mk(0, 1'b0, 3'd2, 24'h000000, 32'h0, NS));
        present(mk(0, 1'b1, 3'd2, 24'h004000, 32'hCAFEF00D, NS));
        present(mk(0, 1'b0, 3'd2, 24'h000000, 32'h0, NS));
        present(mk(0, 1'b0, 3'd2, 24'h004000, 32'h0, NS));
        drain("drain_directed_ws2");
        init_region();
        for (int i = 0; i < 250; i++) present(rnd_item());
        drain("drain_random_ws2");

        // ---- WAIT_STATES = 0 instance ----
        sel = 1;
        init_region();
        present(mk(0, 1'b0, 3'd2, 24'h000040, 32'h0, NS));
        present(mk(0, 1'b0, 3'd2, 24'h000044, 32'h0, SQ));
        present(mk(0, 1'b0, 3'd2, 24'h000048, 32'h0, SQ));
        present(mk(0, 1'b0, 3'd2, 24'h00004C, 32'h0, SQ));
        present(mk(0, 1'b1, 3'd2, 24'h000080, 32'hA5A55A5A, NS));
        present(mk(0, 1'b0, 3'd2, 24'h000080, 32'h0, NS));
        present(mk(0, 1'b0, 3'd2, 24'h000002, 32'h0, NS));
        present(mk(0, 1'b1, 3'd2, 24'h004000, 32'h0BADCAFE, NS));
        present(mk(0, 1'b0, 3'd2, 24'h000000, 32'h0, NS));
        drain("drain_directed_ws0");
        for (int i = 0; i < 250; i++) present(rnd_item());
        drain("drain_random_ws0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahblite3_sram_slave.md
Name: ahblite3_sram_slave

Overview:
- AHB-Lite slave memory that sits directly downstream of the AHB-Lite cache's memory-side master port (io_mem_ahb_*).
- Serves cache line refills and write-throughs from an internal word-organised RAM.
- Inserts a configurable number of wait states so cache miss latency can be exercised.
- Returns ERROR responses for illegal transfers.

Parameters:
- AW, 24, AHB address width; matches the cache memory port.
- DW, 32, data width; only 32 is supported.
- DEPTH_WORDS, 4096, RAM depth in 32-bit words. Byte range is 0 to DEPTH_WORDS*4-1.
- WAIT_STATES, 1, number of HREADYOUT-low cycles per data phase. Legal range 0..7.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- io_ahb_HADDR  in  AW  transfer address
- io_ahb_HSEL  in  1  slave select
- io_ahb_HREADY  in  1  bus ready (previous transfer complete)
- io_ahb_HWRITE  in  1  1 = write
- io_ahb_HSIZE  in  3  0 = byte, 1 = half, 2 = word
- io_ahb_HBURST  in  3  ignored
- io_ahb_HPROT  in  4  ignored
- io_ahb_HTRANS  in  2  0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ
- io_ahb_HMASTLOCK  in  1  ignored
- io_ahb_HWDATA  in  DW  write data, valid in the data phase
- io_ahb_HRDATA  out  DW  read data
- io_ahb_HREADYOUT  out  1  data-phase complete
- io_ahb_HRESP  out  1  0 = OKAY, 1 = ERROR

Behaviour:
- Clock and reset: single clock domain, clk. reset is asynchronous and active-high.
- Reset values:
  - HREADYOUT = 1, HRESP = 0, HRDATA = 0.
  - FSM in IDLE, wait counter = 0, latched address/control cleared.
  - Reset asserted mid-transfer aborts the transfer. A pending write is discarded and the RAM is not modified.
- Accept condition: a transfer is accepted at a rising edge when HSEL & HREADY & HTRANS[1].
  - On accept, latch HADDR, HWRITE and HSIZE.
  - IDLE/BUSY, or HSEL = 0, are not accepted and get a zero-wait OKAY (HREADYOUT stays 1).
- Illegal transfer. Any of the following gives an ERROR response:
  - HSIZE > 2;
  - half access with HADDR[0] = 1;
  - word access with HADDR[1:0] != 0;
  - HADDR >= DEPTH_WORDS*4 (see Optional Feature).
- FSM states IDLE, WAIT, LAST, ERR1, ERR2.
  - IDLE: HREADYOUT = 1, HRESP = 0.
    - Legal accept -> WAIT if WAIT_STATES > 0 (counter loaded with WAIT_STATES-1), else LAST.
    - Illegal accept -> ERR1.
  - WAIT: HREADYOUT = 0. Decrement the counter; -> LAST when the counter = 0. Total low cycles = WAIT_STATES.
  - LAST: HREADYOUT = 1, HRESP = 0. The transfer completes this cycle. A new transfer may be accepted in the same cycle (pipelined address phase).
    - New legal accept -> WAIT/LAST per the IDLE rule.
    - New illegal accept -> ERR1.
    - No accept -> IDLE.
  - ERR1: HREADYOUT = 0, HRESP = 1. -> ERR2.
  - ERR2: HREADYOUT = 1, HRESP = 1. Accept is evaluated as in LAST; no accept -> IDLE.
- Address phases are not sampled while HREADYOUT = 0, because HREADY is low.
- Write:
  - HWDATA is sampled in the LAST cycle. The RAM is updated at the edge that ends LAST.
  - Byte enables: byte -> lane HADDR[1:0]; half -> lanes {HADDR[1],0} and {HADDR[1],1}; word -> all lanes.
  - ERROR transfers never write.
- Read:
  - In WAIT and LAST, HRDATA = RAM[latched HADDR[AW-1:2]] as a full word. The master selects byte lanes.
  - HRDATA = 0 in all other cycles.
  - Write followed by read of the same word in the next pipelined transfer returns the new data.
- Word index: HADDR[AW-1:2]. When DEPTH_WORDS*4 < 2^AW, upper bits are used for the range check only.

Optional Feature:
- Macro: AHB_SRAM_RANGE_ERR_EN.
- Defined: HADDR >= DEPTH_WORDS*4 is illegal and takes the ERR1/ERR2 path. No RAM access occurs.
- Undefined: no range check. The word index wraps modulo DEPTH_WORDS, and the transfer gets a normal OKAY with WAIT_STATES waits.
- The alignment and size checks are always present.

Test Plan:
- Reset, then idle: with reset high, HREADYOUT = 1, HRESP = 0, HRDATA = 0; these hold for 5 idle cycles after release.
- WAIT_STATES = 2:
  - Stimulus: word write 0xDEADBEEF to 0x000010, then pipelined read of 0x000010.
  - Required response: each transfer shows 2 cycles of HREADYOUT = 0 followed by 1 high; the read returns 0xDEADBEEF.
- Byte and half writes:
  - Stimulus: byte 0xAA to 0x21, half 0x5566 to 0x22, over an initial 0x00000000.
  - Required response: word read at 0x20 returns 0x5566AA00.
- WAIT_STATES = 0, 4-beat burst:
  - Stimulus: INCR4 read 0x40..0x4C (NONSEQ then SEQ).
  - Required response: 4 consecutive HREADYOUT-high cycles with the correct data.
- Misaligned word:
  - Stimulus: word read at 0x000002.
  - Required response: one cycle HREADYOUT = 0/HRESP = 1, then one cycle HREADYOUT = 1/HRESP = 1; no RAM change.
- Out of range, 0x004000 with DEPTH_WORDS = 4096:
  - With AHB_SRAM_RANGE_ERR_EN: two-cycle ERROR.
  - Without it: a write there aliases to 0x000000, and a read of 0x000000 returns the written data.
